// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode values and FSM state encoding.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011,
      OP_MOD = 3'b100,
      OP_EQ  = 3'b101,
      OP_GT  = 3'b110,
      OP_LT  = 3'b111
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // Divide and modulo share the iterative divider and the zero-divisor bypass
   function automatic logic isDivOp(input opcode_e op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/alu_divider.sv
// Restoring divider: one quotient bit per clock, WIDTH iterations after start.
// quotient/remainder show the value after the current iteration, so they are
// final in the cycle that done is high and can be captured on that edge.
module alu_divider #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int CW = $clog2(WIDTH);

   logic             busy_q, busy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] quo_q, quo_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] dvs_q, dvs_d;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // One restoring step: shift in the next dividend bit, try subtracting the divisor
   always_comb begin
      shifted   = {rem_q, quo_q[WIDTH-1]};
      trial     = shifted - {1'b0, dvs_q};
      quotient  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
      remainder = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
      done      = busy_q && (cnt_q == '0);
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      if (start) begin
         busy_d = 1'b1;
         cnt_d  = CW'(WIDTH - 1);
         quo_d  = dividend;
         rem_d  = '0;
         dvs_d  = divisor;
      end else if (busy_q) begin
         quo_d = quotient;
         rem_d = remainder;
         if (cnt_q == '0) begin
            busy_d = 1'b0;
         end else begin
            cnt_d = cnt_q - CW'(1);
         end
      end
   end

   // Iteration state registers; reset abandons any division in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         quo_q  <= '0;
         rem_q  <= '0;
         dvs_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         quo_q  <= quo_d;
         rem_q  <= rem_d;
         dvs_q  <= dvs_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU behind a valid/ready handshake with carry/borrow and status flags.
// Build option ALU_ITER_MUL_EN: multiply runs on a shift-add iterator in BUSY
// instead of a single-cycle product.
module seq_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [2:0]         opcode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               flag_zero,
   output logic               flag_dz
);

   state_e               state_q, state_d;
   opcode_e              op_q, op_d;
   logic [2*WIDTH-1:0]   result_q, result_d;
   logic                 zero_q, zero_d;
   logic                 dz_q, dz_d;
   opcode_e              opc;
   logic [WIDTH:0]       sum;
   logic [WIDTH:0]       diff;
   logic [2*WIDTH-1:0]   quick;
   logic [2*WIDTH-1:0]   busyResult;
   logic                 divStart;
   logic                 divDone;
   logic [WIDTH-1:0]     divQuotient;
   logic [WIDTH-1:0]     divRemainder;

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign result    = result_q;
   assign flag_zero = zero_q;
   assign flag_dz   = dz_q;

   alu_divider #(.WIDTH(WIDTH)) uDivider (
      .clk       (clk),
      .reset     (reset),
      .start     (divStart),
      .dividend  (a),
      .divisor   (b),
      .done      (divDone),
      .quotient  (divQuotient),
      .remainder (divRemainder)
   );

`ifdef ALU_ITER_MUL_EN
   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      mcnt_q, mcnt_d;
   logic               mulStart;
   logic               mulDone;
   logic [2*WIDTH-1:0] mulProduct;

   // Shift-add multiplier step: add the shifted multiplicand when the low multiplier bit is set
   always_comb begin
      mulProduct = acc_q + (mplier_q[0] ? mcand_q : '0);
      mulDone    = (state_q == ST_BUSY) && (op_q == OP_MUL) && (mcnt_q == '0);
      acc_d      = acc_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      mcnt_d     = mcnt_q;
      if (mulStart) begin
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a};
         mplier_d = b;
         mcnt_d   = CW'(WIDTH - 1);
      end else if ((state_q == ST_BUSY) && (op_q == OP_MUL)) begin
         acc_d    = mulProduct;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         if (mcnt_q != '0) begin
            mcnt_d = mcnt_q - CW'(1);
         end
      end
   end

   // Multiplier iteration registers
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         mcnt_q   <= '0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         mcnt_q   <= mcnt_d;
      end
   end
`endif

   // Single-cycle results computed straight from the operands at the accept edge
   always_comb begin
      opc  = opcode_e'(opcode);
      sum  = {1'b0, a} + {1'b0, b};
      diff = {1'b0, a} - {1'b0, b};
      quick = '0;
      case (opc)
         OP_ADD:  quick = {{(WIDTH-1){1'b0}}, sum};
         OP_SUB:  quick = {{(WIDTH-1){1'b0}}, diff};
         OP_MUL:  quick = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
         OP_EQ:   quick = {{(2*WIDTH-1){1'b0}}, (a == b)};
         OP_GT:   quick = {{(2*WIDTH-1){1'b0}}, (a > b)};
         OP_LT:   quick = {{(2*WIDTH-1){1'b0}}, (a < b)};
         default: quick = '0;
      endcase
   end

   // Next-state logic: accept in IDLE, iterate in BUSY, hold the result in DONE until drained
   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      result_d   = result_q;
      zero_d     = zero_q;
      dz_d       = dz_q;
      divStart   = 1'b0;
      busyResult = (op_q == OP_DIV) ? {{WIDTH{1'b0}}, divQuotient}
                                    : {{WIDTH{1'b0}}, divRemainder};
`ifdef ALU_ITER_MUL_EN
      mulStart   = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               op_d = opc;
               dz_d = 1'b0;
               if (isDivOp(opc)) begin
                  if (b == '0) begin
                     result_d = '0;
                     zero_d   = 1'b1;
                     dz_d     = 1'b1;
                     state_d  = ST_DONE;
                  end else begin
                     divStart = 1'b1;
                     state_d  = ST_BUSY;
                  end
               end
`ifdef ALU_ITER_MUL_EN
               else if (opc == OP_MUL) begin
                  mulStart = 1'b1;
                  state_d  = ST_BUSY;
               end
`endif
               else begin
                  result_d = quick;
                  zero_d   = (quick == '0);
                  state_d  = ST_DONE;
               end
            end
         end
         ST_BUSY: begin
`ifdef ALU_ITER_MUL_EN
            if (mulDone) begin
               result_d = mulProduct;
               zero_d   = (mulProduct == '0);
               state_d  = ST_DONE;
            end else
`endif
            if (divDone) begin
               result_d = busyResult;
               zero_d   = (busyResult == '0);
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and result registers; reset abandons any operation and clears the outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_ADD;
         result_q <= '0;
         zero_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         dz_q     <= dz_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus randomized operations
// checked against an arithmetic reference model. Honours ALU_ITER_MUL_EN for mul latency.
module tb_seq_alu;
   import alu_pkg::*;

   localparam int W  = 8;
   localparam int RW = 2 * W;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic [2:0]    opcode;
   logic          out_valid;
   logic          out_ready;
   logic [RW-1:0] result;
   logic          flag_zero;
   logic          flag_dz;

   int testsRun    = 0;
   int testsFailed = 0;

   // Free-running 100 MHz clock
   always #5 clk = ~clk;

   seq_alu #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .opcode    (opcode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flag_zero (flag_zero),
      .flag_dz   (flag_dz)
   );

   // Reference result from plain integer arithmetic
   function automatic logic [RW-1:0] refResult(input logic [2:0] op, input logic [W-1:0] va,
                                               input logic [W-1:0] vb);
      int x;
      int y;
      x = int'(va);
      y = int'(vb);
      case (op)
         3'd0:    return RW'(x + y);
         3'd1:    return RW'(((x - y + (1 << W)) % (1 << W)) + ((x < y) ? (1 << W) : 0));
         3'd2:    return RW'(x * y);
         3'd3:    return (y == 0) ? '0 : RW'(x / y);
         3'd4:    return (y == 0) ? '0 : RW'(x % y);
         3'd5:    return (x == y) ? RW'(1) : RW'(0);
         3'd6:    return (x > y) ? RW'(1) : RW'(0);
         default: return (x < y) ? RW'(1) : RW'(0);
      endcase
   endfunction

   // Edges from the accept edge (inclusive) until out_valid is seen
   function automatic int refLatency(input logic [2:0] op, input logic [W-1:0] vb);
      if ((op == 3'd3 || op == 3'd4) && vb != '0) return W + 1;
`ifdef ALU_ITER_MUL_EN
      if (op == 3'd2) return W + 1;
`endif
      return 1;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Issue one operation, check latency/result/flags, stall the consumer, then drain.
   // Entered and left one time unit after a rising edge with the DUT idle.
   task automatic applyStimulus(input string tag, input logic [2:0] op, input logic [W-1:0] va,
                                input logic [W-1:0] vb, input int stall);
      int            lat;
      logic [RW-1:0] expRes;
      logic [RW-1:0] held;
      expRes = refResult(op, va, vb);
      checkOutput({tag, " in_ready before"}, 32'(in_ready), 1);
      in_valid = 1'b1;
      a        = va;
      b        = vb;
      opcode   = op;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      opcode   = 3'($urandom_range(0, 7));
      lat      = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      checkOutput({tag, " latency"}, 32'(lat), 32'(refLatency(op, vb)));
      checkOutput({tag, " result"}, 32'(result), 32'(expRes));
      checkOutput({tag, " flag_zero"}, 32'(flag_zero), 32'(expRes == '0));
      checkOutput({tag, " flag_dz"}, 32'(flag_dz), 32'((op == 3'd3 || op == 3'd4) && vb == '0));
      held = result;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         a        = W'($urandom);
         b        = W'($urandom);
         opcode   = 3'($urandom_range(0, 7));
         @(posedge clk);
         #1;
         checkOutput({tag, " stall result"}, 32'(result), 32'(held));
         checkOutput({tag, " stall out_valid"}, 32'(out_valid), 1);
         checkOutput({tag, " stall in_ready"}, 32'(in_ready), 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checkOutput({tag, " drained out_valid"}, 32'(out_valid), 0);
      checkOutput({tag, " drained in_ready"}, 32'(in_ready), 1);
   endtask

   // Reset mid-division: the op is abandoned and no result ever appears
   task automatic resetDuringDiv();
      int sawValid;
      in_valid = 1'b1;
      a        = W'(100);
      b        = W'(7);
      opcode   = 3'd3;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      checkOutput("midDiv busy in_ready", 32'(in_ready), 0);
      checkOutput("midDiv busy out_valid", 32'(out_valid), 0);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("midDiv reset in_ready", 32'(in_ready), 1);
      checkOutput("midDiv reset out_valid", 32'(out_valid), 0);
      checkOutput("midDiv reset result", 32'(result), 0);
      checkOutput("midDiv reset flag_zero", 32'(flag_zero), 0);
      sawValid = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (out_valid) sawValid++;
      end
      checkOutput("midDiv no out_valid", 32'(sawValid), 0);
   endtask

   initial begin
      logic [2:0]   rop;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      opcode    = '0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset in_ready", 32'(in_ready), 1);
      checkOutput("reset out_valid", 32'(out_valid), 0);
      checkOutput("reset result", 32'(result), 0);
      checkOutput("reset flag_zero", 32'(flag_zero), 0);
      checkOutput("reset flag_dz", 32'(flag_dz), 0);
      reset = 1'b0;
      @(posedge clk);
      #1;

      applyStimulus("add 200+100", 3'd0, W'(200), W'(100), 0);
      applyStimulus("sub 5-7", 3'd1, W'(5), W'(7), 0);
      applyStimulus("sub 7-7", 3'd1, W'(7), W'(7), 0);
      applyStimulus("div 100/7", 3'd3, W'(100), W'(7), 0);
      applyStimulus("mod 100%7", 3'd4, W'(100), W'(7), 1);
      applyStimulus("div 9/0", 3'd3, W'(9), W'(0), 0);
      applyStimulus("mod 9%0", 3'd4, W'(9), W'(0), 0);
      applyStimulus("mul 255*255", 3'd2, W'(255), W'(255), 5);
      applyStimulus("div 255/1", 3'd3, W'(255), W'(1), 0);
      applyStimulus("div 3/200", 3'd3, W'(3), W'(200), 0);
      applyStimulus("eq 42", 3'd5, W'(42), W'(42), 0);
      applyStimulus("gt 1>0", 3'd6, W'(1), W'(0), 0);
      applyStimulus("lt 0<255", 3'd7, W'(0), W'(255), 0);
      applyStimulus("add 255+1", 3'd0, W'(255), W'(1), 2);
      resetDuringDiv();
      applyStimulus("div after reset", 3'd3, W'(100), W'(7), 0);

      for (int n = 0; n < 80; n++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = W'($urandom);
         rb  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
         if ($urandom_range(0, 3) == 0) ra = rb;
         applyStimulus($sformatf("rand%0d op%0d a%0d b%0d", n, rop, ra, rb), rop, ra, rb,
                       int'($urandom_range(0, 2)));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
